// File: rtl/iotdf_frame.sv
// IoT data filter: assembles IN_W-bit samples into a word and applies GRAY2BIN, BIN2GRAY, FIR or frame MAX/MIN.
// Optional FIR datapath is compiled in with `define IOTDF_FIR_EN.
module iotdf_frame #(
  parameter int IN_W      = 8,
  parameter int N_BYTES   = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_en,
  input  logic [IN_W-1:0]           iot_in,
  input  logic [2:0]                fn_sel,
  output logic                      busy,
  output logic                      valid,
  output logic [IN_W*N_BYTES-1:0]   iot_out,
  output logic [1:0]                fsm_state
);

  localparam int W  = IN_W * N_BYTES;
  localparam int CW = $clog2(N_BYTES + 1);
  localparam int FW = $clog2(FRAME_LEN + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CALC = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [2:0] FN_G2B = 3'b001;
  localparam logic [2:0] FN_FIR = 3'b010;
  localparam logic [2:0] FN_B2G = 3'b011;
  localparam logic [2:0] FN_MAX = 3'b100;
  localparam logic [2:0] FN_MIN = 3'b101;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] fcnt, fcnt_nxt, fcnt_inc;
  logic [W-1:0]  word, ext, ext_nxt, g2b, result, cand;
  logic [2:0]    last_fn;
  logic          emit, first;

  // Handshake: a sample moves when in_en is high and busy is low; no other backpressure exists.
  assign busy      = (state != LOAD);
  assign valid     = (state == OUT);
  assign fsm_state = state;

  always_comb begin : gray_decode
    logic acc;
    acc = 1'b0;
    g2b = '0;
    for (int i = W - 1; i >= 0; i--) begin
      acc    = acc ^ word[i];
      g2b[i] = acc;
    end
  end

`ifdef IOTDF_FIR_EN
  logic [W-1:0]          fir;
  logic [W+2*IN_W-1:0]   word_x;
  logic [IN_W+3:0]       s0, s1, s2, t;

  // Two zero slots above the top sample so the upper taps never index out of range.
  assign word_x = {{(2*IN_W){1'b0}}, word};

  always_comb begin
    fir = '0;
    s0  = '0;
    s1  = '0;
    s2  = '0;
    t   = '0;
    for (int k = 0; k < N_BYTES; k++) begin
      s0 = {4'b0, word_x[k*IN_W +: IN_W]};
      s1 = {4'b0, word_x[(k+1)*IN_W +: IN_W]};
      s2 = {4'b0, word_x[(k+2)*IN_W +: IN_W]};
      t  = (s0 << 2) + s0 + (s1 << 3) + s1 + (s2 << 1);
      fir[k*IN_W +: IN_W] = t[IN_W+3:4] + {{(IN_W-1){1'b0}}, t[3]};
    end
  end
`endif

  // A mode change or an empty frame restarts the reduction with the current word.
  always_comb begin
    first = (fcnt == '0) || (fn_sel != last_fn);
    if (first)                 cand = word;
    else if (fn_sel == FN_MAX) cand = (word > ext) ? word : ext;
    else                       cand = (word < ext) ? word : ext;
    fcnt_inc = first ? FW'(1) : fcnt + FW'(1);

    emit     = 1'b0;
    result   = '0;
    fcnt_nxt = fcnt;
    ext_nxt  = ext;
    case (fn_sel)
      FN_G2B: begin
        emit   = 1'b1;
        result = g2b;
      end
`ifdef IOTDF_FIR_EN
      FN_FIR: begin
        emit   = 1'b1;
        result = fir;
      end
`endif
      FN_B2G: begin
        emit   = 1'b1;
        result = word ^ (word >> 1);
      end
      FN_MAX, FN_MIN: begin
        ext_nxt = cand;
        if (fcnt_inc == FW'(FRAME_LEN)) begin
          emit     = 1'b1;
          result   = cand;
          fcnt_nxt = '0;
        end else begin
          fcnt_nxt = fcnt_inc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      fcnt    <= '0;
      ext     <= '0;
      last_fn <= '0;
      word    <= '0;
      iot_out <= '0;
    end else begin
      case (state)
        IDLE: state <= LOAD;
        LOAD: begin
          if (in_en) begin
            word <= (word << IN_W) | W'(iot_in);
            if (cnt == CW'(N_BYTES - 1)) begin
              cnt   <= '0;
              state <= CALC;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        CALC: begin
          last_fn <= fn_sel;
          fcnt    <= fcnt_nxt;
          ext     <= ext_nxt;
          if (emit) begin
            iot_out <= result;
            state   <= OUT;
          end else begin
            state <= LOAD;
          end
        end
        OUT:     state <= LOAD;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
